// File: rtl/dmem_arbiter.sv
// Shares one stb/ack memory bus between instruction fetch and the MEM-stage data port.
// One transfer in flight; the bus request is registered, timed out if unanswered, and acked back one cycle later.
module dmem_arbiter #(
  parameter int TIMEOUT  = 16,
  parameter int D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_if_stb,
  input  logic [31:0] i_if_addr,
  output logic        o_if_ack,
  output logic [31:0] o_if_data,
  input  logic        i_d_stb,
  input  logic        i_d_wr_en,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wr_data,
  output logic        o_d_ack,
  output logic [31:0] o_d_rd_data,
  output logic        o_bus_err,
  output logic        o_mem_stb,
  output logic        o_mem_wr_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rd_data
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(D_STREAK + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSY_IF, S_BUSY_D, S_RESP_IF, S_RESP_D
  } state_e;

  typedef struct packed {
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  state_e        state_q, state_d;
  bus_req_t      req_q, req_d;
  rsp_t          rsp_q, rsp_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          busy, timeout_hit, grant_d, grant_if;

  assign busy        = (state_q == S_BUSY_IF) || (state_q == S_BUSY_D);
  assign timeout_hit = busy && !i_mem_ack && (to_cnt_q == TW'(TIMEOUT - 1));

  // Data has priority until it has starved a waiting fetch D_STREAK times in a row.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_d_stb && !(i_if_stb && (streak_q == SW'(D_STREAK)))) grant_d = 1'b1;
      else if (i_if_stb)                                          grant_if = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      rsp_q    <= '0;
      to_cnt_q <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rsp_q    <= rsp_d;
      to_cnt_q <= to_cnt_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d)       state_d = S_BUSY_D;
        else if (grant_if) state_d = S_BUSY_IF;
      end
      S_BUSY_IF: if (i_mem_ack || timeout_hit) state_d = S_RESP_IF;
      S_BUSY_D:  if (i_mem_ack || timeout_hit) state_d = S_RESP_D;
      S_RESP_IF: state_d = S_IDLE;
      S_RESP_D:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d    = req_q;
    rsp_d    = rsp_q;
    to_cnt_d = to_cnt_q;
    streak_d = streak_q;
    if (grant_d) begin
      req_d    = '{wr_en: i_d_wr_en, addr: i_d_addr, wr_data: i_d_wr_data};
      to_cnt_d = '0;
      // A data grant with a waiting fetch implies streak < D_STREAK, so +1 cannot overflow.
      streak_d = i_if_stb ? streak_q + 1'b1 : '0;
    end else if (grant_if) begin
      req_d    = '{wr_en: 1'b0, addr: i_if_addr, wr_data: 32'd0};
      to_cnt_d = '0;
      streak_d = '0;
    end else if (busy) begin
      if (i_mem_ack) begin
        rsp_d    = '{data: req_q.wr_en ? 32'd0 : i_mem_rd_data, err: 1'b0};
        req_d    = '0;
        to_cnt_d = '0;
      end else if (timeout_hit) begin
        rsp_d    = '{data: 32'd0, err: 1'b1};
        req_d    = '0;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // req_q is only non-zero while busy, so the bus fields come straight from the flops.
  always_comb begin
    o_mem_stb     = busy;
    o_mem_wr_en   = req_q.wr_en;
    o_mem_addr    = req_q.addr;
    o_mem_wr_data = req_q.wr_data;
    o_if_ack      = (state_q == S_RESP_IF);
    o_d_ack       = (state_q == S_RESP_D);
    o_if_data     = o_if_ack ? rsp_q.data : 32'd0;
    o_d_rd_data   = o_d_ack ? rsp_q.data : 32'd0;
    o_bus_err     = (o_if_ack || o_d_ack) && rsp_q.err;
  end

  a_one_ack: assert property (@(posedge clk) disable iff (!rst_n) !(o_if_ack && o_d_ack));
  a_bus_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (o_mem_stb && !i_mem_ack && !timeout_hit) |=> $stable(o_mem_addr) && o_mem_stb);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: request/memory agents, a transaction-level reference model
// compared every cycle, and literal expectations for the documented scenarios.
module tb_dmem_arbiter;
  localparam int TIMEOUT  = 16;
  localparam int D_STREAK = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_if_stb = 1'b0, i_d_stb = 1'b0, i_d_wr_en = 1'b0, i_mem_ack = 1'b0;
  logic [31:0] i_if_addr = '0, i_d_addr = '0, i_d_wr_data = '0, i_mem_rd_data = '0;
  logic        o_if_ack, o_d_ack, o_bus_err, o_mem_stb, o_mem_wr_en;
  logic [31:0] o_if_data, o_d_rd_data, o_mem_addr, o_mem_wr_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.TIMEOUT(TIMEOUT), .D_STREAK(D_STREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_if_stb(i_if_stb), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_data(o_if_data),
    .i_d_stb(i_d_stb), .i_d_wr_en(i_d_wr_en), .i_d_addr(i_d_addr), .i_d_wr_data(i_d_wr_data),
    .o_d_ack(o_d_ack), .o_d_rd_data(o_d_rd_data), .o_bus_err(o_bus_err),
    .o_mem_stb(o_mem_stb), .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr),
    .o_mem_wr_data(o_mem_wr_data), .i_mem_ack(i_mem_ack), .i_mem_rd_data(i_mem_rd_data)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h1234_5678);
  endfunction

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { int port; logic [31:0] data; logic err; int cyc; } ack_t;

  req_t if_q[$], d_q[$], bus_log[$];
  ack_t ack_log[$];
  int   len_log[$];
  int   cyc = 0, d_rise_cyc = 0, mem_lat = 0, stb_cnt = 0;
  bit   force_ack = 1'b0, chk_en = 1'b0;
  req_t tmp_req;
  ack_t tmp_ack;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: who owns the bus, how long it has waited, and a pending response.
  int          m_who = 0, m_age = 0, m_streak = 0, m_rsp_who = 0;
  req_t        m_req;
  logic [31:0] m_rsp_data = '0;
  logic        m_rsp_err = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_who = 0; m_age = 0; m_streak = 0; m_rsp_who = 0;
    end else if (m_rsp_who != 0) begin
      m_rsp_who = 0;
    end else if (m_who != 0) begin
      m_age++;
      if (i_mem_ack) begin
        m_rsp_who = m_who; m_rsp_data = m_req.wr ? 32'd0 : i_mem_rd_data; m_rsp_err = 1'b0; m_who = 0;
      end else if (m_age == TIMEOUT) begin
        m_rsp_who = m_who; m_rsp_data = 32'd0; m_rsp_err = 1'b1; m_who = 0;
      end
    end else if (i_d_stb && !(i_if_stb && m_streak == D_STREAK)) begin
      m_who = 2; m_age = 0;
      m_req.wr = i_d_wr_en; m_req.addr = i_d_addr; m_req.wdata = i_d_wr_data;
      m_streak = i_if_stb ? ((m_streak < D_STREAK) ? m_streak + 1 : D_STREAK) : 0;
    end else if (i_if_stb) begin
      m_who = 1; m_age = 0; m_streak = 0;
      m_req.wr = 1'b0; m_req.addr = i_if_addr; m_req.wdata = 32'd0;
    end
  end

  always @(negedge clk) if (chk_en) begin
    check1("mem_stb", o_mem_stb, m_who != 0);
    check1("mem_wr_en", o_mem_wr_en, (m_who != 0) && m_req.wr);
    check("mem_addr", o_mem_addr, (m_who != 0) ? m_req.addr : 32'd0);
    check("mem_wr_data", o_mem_wr_data, (m_who != 0) ? m_req.wdata : 32'd0);
    check1("if_ack", o_if_ack, m_rsp_who == 1);
    check1("d_ack", o_d_ack, m_rsp_who == 2);
    check1("bus_err", o_bus_err, (m_rsp_who != 0) && m_rsp_err);
    if (m_rsp_who == 1) check("if_data", o_if_data, m_rsp_data);
    if (m_rsp_who == 2) check("d_rd_data", o_d_rd_data, m_rsp_data);
  end

  // Memory agent (acks after mem_lat stb cycles, never if negative) plus bus/ack monitors.
  always @(negedge clk) begin
    if (o_mem_stb === 1'b1) begin
      if (stb_cnt == 0) begin
        tmp_req.wr = o_mem_wr_en; tmp_req.addr = o_mem_addr; tmp_req.wdata = o_mem_wr_data;
        bus_log.push_back(tmp_req);
      end
      i_mem_ack = force_ack || (mem_lat >= 0 && stb_cnt == mem_lat);
      stb_cnt++;
    end else begin
      if (stb_cnt != 0) len_log.push_back(stb_cnt);
      stb_cnt = 0;
      i_mem_ack = force_ack;
    end
    i_mem_rd_data = i_mem_ack ? mem_data(o_mem_addr) : 32'hBAD0_BAD0;
    if (o_if_ack === 1'b1) begin
      tmp_ack.port = 1; tmp_ack.data = o_if_data; tmp_ack.err = o_bus_err; tmp_ack.cyc = cyc;
      ack_log.push_back(tmp_ack);
    end
    if (o_d_ack === 1'b1) begin
      tmp_ack.port = 2; tmp_ack.data = o_d_rd_data; tmp_ack.err = o_bus_err; tmp_ack.cyc = cyc;
      ack_log.push_back(tmp_ack);
    end
  end

  // Requester agents: hold the head request until acked, then present the next one.
  always @(negedge clk) begin
    if (o_if_ack === 1'b1 && if_q.size() != 0) if_q.delete(0);
    if (if_q.size() != 0) begin
      i_if_stb = 1'b1; i_if_addr = if_q[0].addr;
    end else begin
      i_if_stb = 1'b0; i_if_addr = '0;
    end
  end

  always @(negedge clk) begin
    if (o_d_ack === 1'b1 && d_q.size() != 0) d_q.delete(0);
    if (d_q.size() != 0) begin
      if (!i_d_stb) d_rise_cyc = cyc;
      i_d_stb = 1'b1; i_d_wr_en = d_q[0].wr; i_d_addr = d_q[0].addr; i_d_wr_data = d_q[0].wdata;
    end else begin
      i_d_stb = 1'b0; i_d_wr_en = 1'b0; i_d_addr = '0; i_d_wr_data = '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = wd;
    d_q.push_back(r);
  endtask

  task automatic push_if(input logic [31:0] a);
    req_t r;
    r.wr = 1'b0; r.addr = a; r.wdata = '0;
    if_q.push_back(r);
  endtask

  task automatic clear_logs();
    bus_log.delete(); ack_log.delete(); len_log.delete();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i = 0;
    while ((if_q.size() != 0 || d_q.size() != 0 || o_mem_stb === 1'b1) && i < budget) begin
      tick(1);
      i++;
    end
    check1({name, " drained"}, (if_q.size() == 0) && (d_q.size() == 0), 1'b1);
    tick(2);
  endtask

  logic [31:0] t3_exp [7];

  initial begin
    t3_exp = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h40, 32'h310, 32'h314};
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check1("rst mem_stb", o_mem_stb, 1'b0);
    check("rst mem_addr", o_mem_addr, 32'd0);
    check1("rst acks", o_if_ack | o_d_ack | o_bus_err, 1'b0);

    // Spurious ack while idle
    clear_logs();
    force_ack = 1'b1; tick(2); force_ack = 1'b0; tick(2);
    check("t6 acks", ack_log.size(), 0);
    check("t6 bus", bus_log.size(), 0);

    // Single load
    clear_logs(); mem_lat = 0;
    push_d(1'b0, 32'h100, 32'h0);
    wait_idle(50, "t1");
    check("t1 bus n", bus_log.size(), 1);
    if (bus_log.size() >= 1) check("t1 addr", bus_log[0].addr, 32'h100);
    check("t1 stb len", (len_log.size() >= 1) ? len_log[0] : -1, 1);
    check("t1 ack n", ack_log.size(), 1);
    if (ack_log.size() >= 1) begin
      check("t1 port", ack_log[0].port, 2);
      check("t1 data", ack_log[0].data, 32'hDEAD_BEEF);
      check("t1 latency", ack_log[0].cyc - d_rise_cyc, 2);
    end

    // Simultaneous IF and data store: store first
    clear_logs();
    push_if(32'h0); push_d(1'b1, 32'h200, 32'h55);
    wait_idle(50, "t2");
    check("t2 bus n", bus_log.size(), 2);
    if (bus_log.size() >= 2) begin
      check("t2 first addr", bus_log[0].addr, 32'h200);
      check1("t2 first wr", bus_log[0].wr, 1'b1);
      check("t2 first wdata", bus_log[0].wdata, 32'h55);
      check("t2 second addr", bus_log[1].addr, 32'h0);
    end
    if (ack_log.size() >= 2) begin
      check("t2 ack0 port", ack_log[0].port, 2);
      check("t2 ack0 data", ack_log[0].data, 32'h0);
      check("t2 ack1 port", ack_log[1].port, 1);
      check("t2 ack1 data", ack_log[1].data, 32'h1234_5678);
    end

    // Data streak limit
    clear_logs();
    push_if(32'h40);
    for (int k = 0; k < 6; k++) push_d(1'b0, 32'h300 + 32'(4 * k), 32'h0);
    wait_idle(200, "t3");
    check("t3 bus n", bus_log.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < bus_log.size()) check($sformatf("t3 grant%0d", k), bus_log[k].addr, t3_exp[k]);

    // Timeout, then a late ack
    clear_logs(); mem_lat = -1;
    push_d(1'b0, 32'h500, 32'h0);
    wait_idle(100, "t4");
    check("t4 stb len", (len_log.size() >= 1) ? len_log[0] : -1, TIMEOUT);
    check("t4 ack n", ack_log.size(), 1);
    if (ack_log.size() >= 1) begin
      check("t4 port", ack_log[0].port, 2);
      check1("t4 err", ack_log[0].err, 1'b1);
      check("t4 data", ack_log[0].data, 32'h0);
    end
    clear_logs();
    force_ack = 1'b1; tick(1); force_ack = 1'b0; tick(3);
    check("t4 late ack", ack_log.size(), 0);
    mem_lat = 0;

    // Reset in the middle of an IF transfer
    clear_logs(); mem_lat = -1;
    push_if(32'h80);
    begin
      int i = 0;
      while (o_mem_stb !== 1'b1 && i < 20) begin tick(1); i++; end
    end
    check1("t5 busy", o_mem_stb, 1'b1);
    tick(3);
    rst_n = 1'b0; if_q.delete();
    tick(1);
    rst_n = 1'b1;
    check1("t5 rst stb", o_mem_stb, 1'b0);
    check("t5 rst addr", o_mem_addr, 32'd0);
    force_ack = 1'b1; tick(1); force_ack = 1'b0; mem_lat = 0; tick(3);
    check("t5 no ack", ack_log.size(), 0);
    clear_logs();
    push_d(1'b0, 32'h104, 32'h0);
    wait_idle(50, "t5");
    check("t5 ack n", ack_log.size(), 1);
    if (ack_log.size() >= 1) check("t5 data", ack_log[0].data, 32'h1234_577C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
